// File: rtl/updown_sweep_arbiter.sv
// Round-robin arbiter that lends one shared up/down count register to two
// requesters; each grant runs a load-then-step sweep from start to end.
module updown_sweep_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rt_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_start,
   input  logic [WIDTH-1:0] req0_end,
   input  logic             req0_dir,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_start,
   input  logic [WIDTH-1:0] req1_end,
   input  logic             req1_dir,
   input  logic             abort,
   output logic [WIDTH-1:0] Q,
   output logic             busy,
   output logic             owner,
   output logic             done,
   output logic             done_aborted
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] end_q, end_d;
   logic             dir_q, dir_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic             abort_pend_q, abort_pend_d;
   logic             aborted_q, aborted_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             grant0, grant1;

   // On contention, the requester that did not win last time gets the grant.
   assign grant0 = req0_valid & (~req1_valid | last_q);
   assign grant1 = req1_valid & (~req0_valid | ~last_q);

   always_comb begin
      state_d      = state_q;
      q_d          = q_q;
      start_d      = start_q;
      end_d        = end_q;
      dir_d        = dir_q;
      owner_d      = owner_q;
      last_d       = last_q;
      abort_pend_d = abort_pend_q;
      aborted_d    = 1'b0;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      case (state_q)
         S_IDLE: begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (grant0 | grant1) begin
               owner_d      = grant1;
               last_d       = grant1;
               start_d      = grant1 ? req1_start : req0_start;
               end_d        = grant1 ? req1_end   : req0_end;
               dir_d        = grant1 ? req1_dir   : req0_dir;
               abort_pend_d = 1'b0;
               state_d      = S_LOAD;
            end
         end
         S_LOAD: begin
            // An abort seen during LOAD is remembered and honoured one edge later.
            q_d          = start_q;
            abort_pend_d = abort;
            state_d      = S_SWEEP;
         end
         S_SWEEP: begin
            if (abort | abort_pend_q) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end else if (q_q == end_q) begin
               state_d = S_DONE;
            end else begin
               q_d = dir_q ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_LOAD) | (state_d == S_SWEEP);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rt_n) begin
      if (!rt_n) begin
         state_q      <= S_IDLE;
         q_q          <= '0;
         start_q      <= '0;
         end_q        <= '0;
         dir_q        <= 1'b0;
         owner_q      <= 1'b0;
         last_q       <= 1'b1;
         abort_pend_q <= 1'b0;
         aborted_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         q_q          <= q_d;
         start_q      <= start_d;
         end_q        <= end_d;
         dir_q        <= dir_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         abort_pend_q <= abort_pend_d;
         aborted_q    <= aborted_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign Q            = q_q;
   assign busy         = busy_q;
   assign owner        = owner_q;
   assign done         = done_q;
   assign done_aborted = aborted_q;

endmodule

// File: tb/tb_updown_sweep_arbiter.sv
// Scoreboard bench: a grant/latency model predicts each sweep at handshake,
// a monitor compares Q trajectory, status and completion every cycle.
module tb_updown_sweep_arbiter;

   logic       clk = 1'b0;
   logic       rt_n;
   logic       v [2];
   logic [7:0] st [2];
   logic [7:0] en [2];
   logic       dr [2];
   logic       abort;
   logic       req0_ready, req1_ready;
   logic [7:0] Q;
   logic       busy, owner, done, done_aborted;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int         id;
      logic [7:0] st;
      logic [7:0] en;
      logic       dr;
      int         hs;
      int         steps;
   } item_t;

   item_t      sb_q[$];
   int         abort_edges[$];
   int         free_edge   = 0;
   int         m_last      = 1;
   int         m_owner     = 0;
   logic [7:0] m_q         = 8'd0;

   updown_sweep_arbiter #(.WIDTH(8)) dut (
      .clk(clk), .rt_n(rt_n),
      .req0_valid(v[0]), .req0_ready(req0_ready), .req0_start(st[0]),
      .req0_end(en[0]), .req0_dir(dr[0]),
      .req1_valid(v[1]), .req1_ready(req1_ready), .req1_start(st[1]),
      .req1_end(en[1]), .req1_dir(dr[1]),
      .abort(abort), .Q(Q), .busy(busy), .owner(owner), .done(done),
      .done_aborted(done_aborted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rt_n && abort) abort_edges.push_back(cyc + 1);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] qat(input logic [7:0] s, input logic dir, input int k);
      logic [7:0] kk;
      kk = k[7:0];
      return dir ? s + kk : s - kk;
   endfunction

   // Sweep length after aborts: the first abort sampled on the LOAD edge or
   // any SWEEP evaluation edge freezes Q at that point.
   task automatic eff(input item_t it, output int se, output bit ab);
      se = it.steps;
      ab = 1'b0;
      foreach (abort_edges[k]) begin
         if (!ab && abort_edges[k] >= it.hs + 1 && abort_edges[k] <= it.hs + 2 + it.steps) begin
            ab = 1'b1;
            se = (abort_edges[k] == it.hs + 1) ? 0 : abort_edges[k] - it.hs - 2;
         end
      end
   endtask

   // Model: predicts grants (and hence ready) from the valids and history.
   always @(negedge clk) begin
      #1;
      if (rt_n) begin
         int e0, e1;
         e0 = 0;
         e1 = 0;
         if (sb_q.size() == 0 && cyc + 1 >= free_edge && (v[0] || v[1])) begin
            item_t it;
            int    g;
            logic [7:0] d;
            if (v[0] && v[1]) g = (m_last == 1) ? 0 : 1;
            else g = v[1] ? 1 : 0;
            if (g == 0) e0 = 1; else e1 = 1;
            it.id = g; it.st = st[g]; it.en = en[g]; it.dr = dr[g];
            it.hs = cyc + 1;
            d = dr[g] ? en[g] - st[g] : st[g] - en[g];
            it.steps = int'(d);
            sb_q.push_back(it);
            m_last = g;
         end
         chk("ready0", int'(req0_ready), e0);
         chk("ready1", int'(req1_ready), e1);
      end
   end

   // Monitor: compares DUT outputs against the active scoreboard entry.
   always @(negedge clk) begin
      if (rt_n) begin
         if (sb_q.size() != 0 && sb_q[0].hs <= cyc) begin
            item_t it;
            int    se, lat;
            bit    ab;
            it = sb_q[0];
            eff(it, se, ab);
            lat = se + 2;
            chk("owner_busy", int'(owner), it.id);
            chk("busy", int'(busy), (cyc < it.hs + lat) ? 1 : 0);
            if (cyc == it.hs) chk("q_load_hold", int'(Q), int'(m_q));
            else chk("q_sweep", int'(Q), int'(qat(it.st, it.dr, (cyc - it.hs - 1 < se) ? cyc - it.hs - 1 : se)));
            if (cyc >= it.hs + lat) begin
               chk("done_pulse", int'(done), 1);
               chk("done_aborted", int'(done_aborted), ab ? 1 : 0);
               m_q       = qat(it.st, it.dr, se);
               m_owner   = it.id;
               free_edge = cyc + 2;
               void'(sb_q.pop_front());
            end else begin
               chk("done_early", int'(done), 0);
               chk("aborted_idle", int'(done_aborted), 0);
            end
         end else begin
            chk("done_idle", int'(done), 0);
            chk("busy_idle", int'(busy), 0);
            chk("q_idle", int'(Q), int'(m_q));
            chk("owner_idle", int'(owner), m_owner);
         end
      end
   end

   task automatic send(input int id, input logic [7:0] s, input logic [7:0] e, input logic d);
      bit ok;
      ok = 1'b0;
      st[id] = s; en[id] = e; dr[id] = d; v[id] = 1'b1;
      for (int n = 0; n < 2000 && !ok; n++) begin
         @(negedge clk);
         if ((id == 0) ? req0_ready : req1_ready) ok = 1'b1;
      end
      if (!ok) chk("handshake_timeout", 0, 1);
      @(posedge clk);
      #1;
      v[id] = 1'b0;
   endtask

   task automatic send_rand(input int id);
      logic [7:0] s, dl;
      logic       d;
      s  = 8'($urandom_range(0, 255));
      dl = 8'($urandom_range(0, 12));
      d  = 1'($urandom_range(0, 1));
      send(id, s, d ? s + dl : s - dl, d);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 3000 && !ok; n++) begin
         @(posedge clk);
         if (sb_q.size() == 0) ok = 1'b1;
      end
      if (!ok) chk("idle_timeout", 0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rt_n = 1'b0; abort = 1'b0;
      for (int i = 0; i < 2; i++) begin
         v[i] = 1'b0; st[i] = 8'd0; en[i] = 8'd0; dr[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_q", int'(Q), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_owner", int'(owner), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_aborted", int'(done_aborted), 0);
      chk("rst_ready0", int'(req0_ready), 0);
      chk("rst_ready1", int'(req1_ready), 0);
      rt_n = 1'b1;

      send(0, 8'd10, 8'd14, 1'b1);  wait_idle();
      send(1, 8'd250, 8'd3, 1'b1);  wait_idle();
      send(1, 8'd2, 8'd254, 1'b0);  wait_idle();
      send(0, 8'd77, 8'd77, 1'b1);  wait_idle();

      fork
         for (int k = 0; k < 4; k++) send_rand(0);
         for (int k = 0; k < 4; k++) send_rand(1);
      join
      wait_idle();

      send(0, 8'd0, 8'd100, 1'b1);
      repeat (41) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      wait_idle();

      abort = 1'b1;
      repeat (3) @(posedge clk);
      #1 abort = 1'b0;
      send(1, 8'd5, 8'd8, 1'b1);    wait_idle();

      send(1, 8'd30, 8'd20, 1'b0);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      wait_idle();

      for (int k = 0; k < 8; k++) begin
         send_rand(int'($urandom_range(0, 1)));
         wait_idle();
      end

      send(0, 8'd0, 8'd50, 1'b1);
      repeat (10) @(posedge clk);
      #3 rt_n = 1'b0;
      sb_q.delete();
      free_edge = 0; m_last = 1; m_owner = 0; m_q = 8'd0;
      #1;
      chk("midrst_q", int'(Q), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      @(posedge clk);
      #1 rt_n = 1'b1;
      fork
         send(1, 8'd9, 8'd11, 1'b1);
         send(0, 8'd60, 8'd58, 1'b0);
      join
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/updown_sweep_arbiter.md
Name: updown_sweep_arbiter

Overview:
- Shares one 8-bit up/down count register between two requesters.
- Each request is a "sweep": load a start value, then count up or down one step per clock until an end value is reached.
- The block arbitrates the requests round-robin, sequences load and count, and reports completion with the ID of the requester it served.
- It sits between the command sources and any logic that consumes the count value Q.

Parameters:
WIDTH, 8, width of count register and start/end fields

Ports:
clk  input  1  clock, rising edge
rt_n  input  1  reset, asynchronous, active-low
req0_valid  input  1  requester 0 has a sweep command
req0_ready  output  1  requester 0 command accepted this cycle
req0_start  input  WIDTH  requester 0 start value
req0_end  input  WIDTH  requester 0 end value
req0_dir  input  1  requester 0 direction (1=up, 0=down)
req1_valid / req1_ready / req1_start / req1_end / req1_dir  same as requester 0
abort  input  1  terminate the active sweep
Q  output  WIDTH  count register value
busy  output  1  sweep in progress (LOAD or SWEEP)
owner  output  1  ID of the granted requester, valid while busy or done
done  output  1  one-cycle completion pulse
done_aborted  output  1  qualifies done: 1 = sweep was aborted

Behaviour:
- Clock and reset: one clock, clk. Reset rt_n is asynchronous and active-low.
- Reset values: state=IDLE, Q=0, busy=0, owner=0, done=0, done_aborted=0, both ready=0, last_grant=1 (so requester 0 wins the first tie).
- Reset asserted mid-sweep: immediate return to reset values; the sweep in progress is lost, with no done pulse.
- States:
  - IDLE: Q holds.
  - LOAD: lasts one cycle.
  - SWEEP: steps Q toward the end value.
  - DONE: lasts one cycle.
- Arbitration (IDLE only):
  - If exactly one valid is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted.
  - reqN_ready is combinational: high only in IDLE for the granted requester.
- Handshake and capture:
  - A command is accepted when valid&&ready at a clock edge.
  - On acceptance, start/end/dir are captured, owner and last_grant are updated, and the state moves to LOAD.
  - Requesters must hold valid and payload stable until ready; valid may not be withdrawn.
- LOAD: at the next edge Q<=start, state moves to SWEEP.
- SWEEP, evaluated at each edge, in priority order:
  - abort: go to DONE with done_aborted=1; Q holds.
  - Q==end: go to DONE with done_aborted=0; Q holds.
  - otherwise: Q<=Q+1 if dir=1, or Q<=Q-1 if dir=0, modulo 2^WIDTH (wrap-around is legal).
- Abort in LOAD: the load still completes, then the state moves to DONE with done_aborted=1 at the following edge.
- abort in IDLE or DONE is ignored.
- Step count: up = (end-start) mod 2^W; down = (start-end) mod 2^W. start==end gives zero steps.
- Latency: with the handshake at edge E0, done is high for the cycle following edge E0+2+steps.
- Status outputs:
  - busy=1 in LOAD and SWEEP.
  - done=1 only in DONE; done_aborted is valid only while done=1, and 0 otherwise.
  - owner is unchanged until the next grant.
- DONE always returns to IDLE. A pending valid can be granted in the IDLE cycle that follows, so there is at least one idle cycle between sweeps. ready is never high in LOAD, SWEEP or DONE.
- All outputs except ready are registered.

Test Plan:
- Reset then req0 {start=10, end=14, up}:
  - ready0 high in the first IDLE cycle.
  - Q=10,11,12,13,14 on consecutive edges.
  - done=1, owner=0, done_aborted=0 exactly 6 cycles after the handshake edge.
- Wrap-around: req1 {start=250, end=3, up} -> Q passes 255→0, 9 steps, done owner=1. Then {start=2, end=254, down} -> Q passes 0→255, 4 steps.
- start==end=77 -> Q=77 after LOAD, done on the next cycle, zero steps.
- Contention: both valid high continuously after reset -> grants alternate 0,1,0,1. Each waiting requester keeps ready=0 while busy.
- abort asserted while Q=40 in sweep {0→100 up} -> Q frozen at 40, done=1 with done_aborted=1, then IDLE. abort pulsed in IDLE -> no effect.
- rt_n dropped asynchronously mid-sweep (between edges) -> Q=0, busy=0, no done pulse. After release, the first grant goes to req0.
